// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: pipeline writes take priority, multi-cycle aux results
// wait in a 2-entry FIFO and stall the pipeline once they have been denied too long.
module reg_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_write,
    input  logic [3:0]  pipe_write_index,
    input  logic [31:0] pipe_write_data,
    input  logic        pipe_write_immediate,
    input  logic [15:0] pipe_write_immediate_data,
    input  logic [1:0]  pipe_write_immediate_type,
    input  logic        aux_valid,
    input  logic [3:0]  aux_index,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        write,
    output logic [3:0]  write_index,
    output logic [31:0] write_data,
    output logic        write_immediate,
    output logic [15:0] write_immediate_data,
    output logic [1:0]  write_immediate_type,
    output logic        stall,
    output logic [15:0] pending_mask
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

    logic [1:0][3:0]  fifo_idx_q, fifo_idx_d;
    logic [1:0][31:0] fifo_data_q, fifo_data_d;
    logic [1:0]       count_q, count_d;
    logic [2:0]       starve_q, starve_d;

    logic        out_write_q, out_write_d;
    logic [3:0]  out_index_q, out_index_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_imm_q, out_imm_d;
    logic [15:0] out_imm_data_q, out_imm_data_d;
    logic [1:0]  out_imm_type_q, out_imm_type_d;

    logic        pipe_req;
    logic        accept;
    logic        aux_grant;
    logic        head_killed;
    logic [2:0]  cand_v;
    logic [2:0][3:0]  cand_idx;
    logic [2:0][31:0] cand_data;
    logic [1:0]  n_keep;

    always_comb begin
        pipe_req    = pipe_write | pipe_write_immediate;
        aux_ready   = (count_q != 2'd2);
        accept      = aux_valid & aux_ready;
        aux_grant   = !pipe_req && (count_q != 2'd0);
        head_killed = pipe_req && (count_q != 2'd0) && (fifo_idx_q[0] == pipe_write_index);

        // Candidate slots in age order: head, second entry, new offer.
        cand_v    = {accept, (count_q == 2'd2), (count_q != 2'd0) && !aux_grant};
        cand_idx  = {aux_index, fifo_idx_q[1], fifo_idx_q[0]};
        cand_data = {aux_data, fifo_data_q[1], fifo_data_q[0]};
        if (pipe_req) begin
            for (int i = 0; i < 3; i++) begin
                if (cand_idx[i] == pipe_write_index) begin
                    cand_v[i] = 1'b0;
                end
            end
        end

        fifo_idx_d  = fifo_idx_q;
        fifo_data_d = fifo_data_q;
        n_keep      = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (cand_v[i]) begin
                if (n_keep == 2'd0) begin
                    fifo_idx_d[0]  = cand_idx[i];
                    fifo_data_d[0] = cand_data[i];
                end else begin
                    fifo_idx_d[1]  = cand_idx[i];
                    fifo_data_d[1] = cand_data[i];
                end
                n_keep = n_keep + 2'd1;
            end
        end
        count_d = n_keep;

        if (aux_grant || head_killed || (count_d == 2'd0)) begin
            starve_d = 3'd0;
        end else if ((count_q != 2'd0) && (starve_q != 3'd7)) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end

        stall = (starve_q >= STARVE_LIM);

        pending_mask = 16'h0000;
        if (count_q != 2'd0) begin
            pending_mask[fifo_idx_q[0]] = 1'b1;
        end
        if (count_q == 2'd2) begin
            pending_mask[fifo_idx_q[1]] = 1'b1;
        end
    end

    always_comb begin
        out_write_d    = 1'b0;
        out_imm_d      = 1'b0;
        out_index_d    = out_index_q;
        out_data_d     = out_data_q;
        out_imm_data_d = out_imm_data_q;
        out_imm_type_d = out_imm_type_q;
        if (pipe_req) begin
            out_write_d    = pipe_write;
            out_imm_d      = pipe_write_immediate;
            out_index_d    = pipe_write_index;
            out_data_d     = pipe_write_data;
            out_imm_data_d = pipe_write_immediate_data;
            out_imm_type_d = pipe_write_immediate_type;
        end else if (aux_grant) begin
            out_write_d = 1'b1;
            out_index_d = fifo_idx_q[0];
            out_data_d  = fifo_data_q[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_idx_q     <= '0;
            fifo_data_q    <= '0;
            count_q        <= 2'd0;
            starve_q       <= 3'd0;
            out_write_q    <= 1'b0;
            out_index_q    <= 4'd0;
            out_data_q     <= 32'd0;
            out_imm_q      <= 1'b0;
            out_imm_data_q <= 16'd0;
            out_imm_type_q <= 2'd0;
        end else begin
            fifo_idx_q     <= fifo_idx_d;
            fifo_data_q    <= fifo_data_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            out_write_q    <= out_write_d;
            out_index_q    <= out_index_d;
            out_data_q     <= out_data_d;
            out_imm_q      <= out_imm_d;
            out_imm_data_q <= out_imm_data_d;
            out_imm_type_q <= out_imm_type_d;
        end
    end

    assign write                = out_write_q;
    assign write_index          = out_index_q;
    assign write_data           = out_data_q;
    assign write_immediate      = out_imm_q;
    assign write_immediate_data = out_imm_data_q;
    assign write_immediate_type = out_imm_type_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: a queue-based reference model predicts each
// granted write; the scoreboard pops one record per cycle the DUT shows a write.
module tb_reg_write_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_write;
    logic [3:0]  pipe_write_index;
    logic [31:0] pipe_write_data;
    logic        pipe_write_immediate;
    logic [15:0] pipe_write_immediate_data;
    logic [1:0]  pipe_write_immediate_type;
    logic        aux_valid;
    logic [3:0]  aux_index;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        write;
    logic [3:0]  write_index;
    logic [31:0] write_data;
    logic        write_immediate;
    logic [15:0] write_immediate_data;
    logic [1:0]  write_immediate_type;
    logic        stall;
    logic [15:0] pending_mask;

    reg_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .pipe_write(pipe_write),
        .pipe_write_index(pipe_write_index),
        .pipe_write_data(pipe_write_data),
        .pipe_write_immediate(pipe_write_immediate),
        .pipe_write_immediate_data(pipe_write_immediate_data),
        .pipe_write_immediate_type(pipe_write_immediate_type),
        .aux_valid(aux_valid),
        .aux_index(aux_index),
        .aux_data(aux_data),
        .aux_ready(aux_ready),
        .write(write),
        .write_index(write_index),
        .write_data(write_data),
        .write_immediate(write_immediate),
        .write_immediate_data(write_immediate_data),
        .write_immediate_type(write_immediate_type),
        .stall(stall),
        .pending_mask(pending_mask)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic        w;
        logic        wi;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [15:0] imd;
        logic [1:0]  imt;
    } wr_t;

    ent_t mq[$];
    wr_t  exp_q[$];
    int   m_starve;
    logic [3:0]  l_idx;
    logic [31:0] l_data;
    logic [15:0] l_imd;
    logic [1:0]  l_imt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic preq, acc, agrant, hk;
        int   n0;
        ent_t e;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_starve = 0;
            l_idx = '0; l_data = '0; l_imd = '0; l_imt = '0;
            return;
        end
        preq   = pipe_write | pipe_write_immediate;
        n0     = mq.size();
        acc    = aux_valid && (n0 < 2);
        agrant = !preq && (n0 > 0);
        hk     = preq && (n0 > 0) && (mq[0].idx == pipe_write_index);
        if (preq) begin
            l_idx = pipe_write_index; l_data = pipe_write_data;
            l_imd = pipe_write_immediate_data; l_imt = pipe_write_immediate_type;
            exp_q.push_back({pipe_write, pipe_write_immediate, l_idx, l_data, l_imd, l_imt});
        end else if (agrant) begin
            e = mq.pop_front();
            l_idx = e.idx; l_data = e.data;
            exp_q.push_back({1'b1, 1'b0, l_idx, l_data, l_imd, l_imt});
        end
        if (acc) mq.push_back({aux_index, aux_data});
        if (preq) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].idx == pipe_write_index) mq.delete(i);
            end
        end
        if (agrant || hk || mq.size() == 0) m_starve = 0;
        else if (n0 > 0 && m_starve < 7) m_starve = m_starve + 1;
    endtask

    task automatic check_outputs();
        logic [15:0] m;
        wr_t e;
        m = '0;
        foreach (mq[i]) m[mq[i].idx] = 1'b1;
        chk("aux_ready", 32'(aux_ready), 32'(mq.size() < 2));
        chk("stall", 32'(stall), 32'(m_starve >= LIMIT));
        chk("pending_mask", 32'(pending_mask), 32'(m));
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = {1'b0, 1'b0, l_idx, l_data, l_imd, l_imt};
        chk("write", 32'(write), 32'(e.w));
        chk("write_immediate", 32'(write_immediate), 32'(e.wi));
        chk("write_index", 32'(write_index), 32'(e.idx));
        chk("write_data", write_data, e.data);
        chk("write_immediate_data", 32'(write_immediate_data), 32'(e.imd));
        chk("write_immediate_type", 32'(write_immediate_type), 32'(e.imt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic go_idle();
        pipe_write = 1'b0;
        pipe_write_immediate = 1'b0;
        aux_valid = 1'b0;
    endtask

    task automatic pipe(input logic [3:0] idx, input logic [31:0] data);
        pipe_write = 1'b1;
        pipe_write_index = idx;
        pipe_write_data = data;
    endtask

    task automatic offer(input logic [3:0] idx, input logic [31:0] data);
        aux_valid = 1'b1;
        aux_index = idx;
        aux_data = data;
    endtask

    initial begin
        reset = 1'b1;
        pipe_write = 1'b0; pipe_write_index = '0; pipe_write_data = '0;
        pipe_write_immediate = 1'b0; pipe_write_immediate_data = '0; pipe_write_immediate_type = '0;
        aux_valid = 1'b0; aux_index = '0; aux_data = '0;
        tick();
        tick();
        chk("rst_aux_ready", 32'(aux_ready), 32'd1);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_pending", 32'(pending_mask), 32'd0);
        reset = 1'b0;
        tick();

        // Idle pipeline write
        pipe(4'd3, 32'h1234_5678);
        tick();
        chk("idle_write", 32'(write), 32'd1);
        chk("idle_index", 32'(write_index), 32'd3);
        chk("idle_data", write_data, 32'h1234_5678);
        go_idle();

        // Aux only
        offer(4'd5, 32'hA5A5_A5A5);
        tick();
        chk("aux_pending", 32'(pending_mask), 32'h0020);
        go_idle();
        tick();
        chk("aux_grant_idx", 32'(write_index), 32'd5);
        chk("aux_grant_data", write_data, 32'hA5A5_A5A5);
        tick();

        // Backpressure and starvation
        pipe(4'd1, 32'h100);
        offer(4'd8, 32'h8888);
        tick();
        offer(4'd9, 32'h9999);
        tick();
        chk("bp_ready_low", 32'(aux_ready), 32'd0);
        offer(4'd10, 32'hAAAA);
        tick();
        aux_valid = 1'b0;
        tick();
        chk("bp_no_stall_yet", 32'(stall), 32'd0);
        tick();
        chk("bp_stall", 32'(stall), 32'd1);
        pipe_write = 1'b0;
        pipe_write_immediate = 1'b1; pipe_write_index = 4'd4;
        pipe_write_immediate_data = 16'h1111; pipe_write_immediate_type = 2'd1;
        tick();
        chk("stall_imm_granted", 32'(write_immediate), 32'd1);
        go_idle();
        tick();
        chk("drain_stall_clear", 32'(stall), 32'd0);
        chk("drain_index", 32'(write_index), 32'd8);
        chk("drain_pending", 32'(pending_mask), 32'h0200);
        tick();
        tick();

        // Kill of a buffered entry
        pipe(4'd4, 32'h44);
        offer(4'd7, 32'h77);
        tick();
        aux_valid = 1'b0;
        pipe(4'd7, 32'h1);
        tick();
        chk("kill_pending", 32'(pending_mask), 32'h0000);
        go_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("kill_no_r7", 32'(write), 32'd0);
        end

        // Same-edge accept and kill
        pipe(4'd6, 32'h66);
        offer(4'd6, 32'hDEAD);
        tick();
        chk("same_edge_kill", 32'(pending_mask), 32'h0000);
        go_idle();
        tick();

        // Head discarded, second entry survives
        pipe(4'd2, 32'h22);
        offer(4'd11, 32'hB0B0);
        tick();
        offer(4'd12, 32'hC0C0);
        tick();
        aux_valid = 1'b0;
        pipe(4'd11, 32'h11);
        tick();
        chk("compact_pending", 32'(pending_mask), 32'h1000);
        go_idle();
        tick();
        chk("compact_grant", 32'(write_index), 32'd12);
        tick();

        // Simultaneous accept and pop at count 1
        offer(4'd13, 32'hD0D0);
        tick();
        offer(4'd14, 32'hE0E0);
        tick();
        chk("accpop_idx", 32'(write_index), 32'd13);
        chk("accpop_pending", 32'(pending_mask), 32'h4000);
        go_idle();
        tick();
        chk("accpop_second", 32'(write_index), 32'd14);
        tick();

        // Immediate write
        pipe_write_immediate = 1'b1; pipe_write_index = 4'd2;
        pipe_write_immediate_data = 16'hBEEF; pipe_write_immediate_type = 2'd2;
        tick();
        chk("imm_flag", 32'(write_immediate), 32'd1);
        chk("imm_no_write", 32'(write), 32'd0);
        chk("imm_data", 32'(write_immediate_data), 32'h0000BEEF);
        chk("imm_type", 32'(write_immediate_type), 32'd2);
        go_idle();
        tick();

        // Reset mid-operation
        pipe(4'd0, 32'h0);
        offer(4'd3, 32'h3333);
        tick();
        offer(4'd5, 32'h5555);
        tick();
        offer(4'd15, 32'hFFFF);
        for (int i = 0; i < 3; i++) tick();
        chk("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        go_idle();
        chk("mid_rst_ready", 32'(aux_ready), 32'd1);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_pending", 32'(pending_mask), 32'd0);
        chk("mid_rst_write", 32'(write), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // Random traffic on a small index set to provoke kills
        for (int i = 0; i < 400; i++) begin
            pipe_write = ($urandom_range(0, 3) == 0);
            pipe_write_immediate = ($urandom_range(0, 7) == 0);
            pipe_write_index = 4'($urandom_range(0, 3));
            pipe_write_data = $urandom;
            pipe_write_immediate_data = 16'($urandom);
            pipe_write_immediate_type = 2'($urandom);
            aux_valid = ($urandom_range(0, 1) == 1);
            aux_index = 4'($urandom_range(0, 3));
            aux_data = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        go_idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
